// File: rtl/irq_pending_ctrl_pkg.sv
// Shared widths and FSM encoding for the interrupt pending controller.
package irq_pending_ctrl_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/irq_pending_ctrl_prio_enc16.sv
// Combinational 16-to-4 priority encoder; the highest set index wins.
module prio_enc16
  import irq_pending_ctrl_pkg::*;
(
  input  logic [N_LINES-1:0] in_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               any_o
);

  always_comb begin
    code_o = '0;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int i = 0; i < N_LINES; i++) begin
      if (in_i[i]) begin
        code_o = CODE_W'(i);
      end
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-captured interrupt pending register with a two-state grant/handshake
// presenter. All outputs come straight from flops.
//
// state      | meaning
// ST_IDLE    | nothing presented; grant the highest eligible pending line
// ST_PRESENT | out_code held with out_valid=1 until out_ready
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LINES-1:0]  req,
  input  logic [N_LINES-1:0]  mask,
  input  logic                out_ready,
  input  logic                clr_ovf,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_valid,
  output logic [N_LINES-1:0]  pending,
  output logic                overflow
);

  state_e               state_q;
  logic [N_LINES-1:0]   req_q;
  logic [N_LINES-1:0]   pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic [CODE_W-1:0]    out_code_q;
  logic                 out_valid_q;

  logic [N_LINES-1:0]   rise;
  logic [N_LINES-1:0]   serve_vec;
  logic [N_LINES-1:0]   eligible;
  logic [CODE_W-1:0]    enc_code;
  logic                 enc_any;
  logic                 handshake;

  assign rise      = req & ~req_q;
  assign handshake = (state_q == ST_PRESENT) && out_valid_q && out_ready;
  assign eligible  = pending_q & mask;

  always_comb begin
    serve_vec = '0;
    if (handshake) begin
      serve_vec[out_code_q] = 1'b1;
    end
  end

  // A rise on the line being served re-arms it in the same edge.
  assign pending_d  = (pending_q & ~serve_vec) | rise;
  assign overflow_d = (|(rise & pending_q)) ? 1'b1 :
                      (clr_ovf ? 1'b0 : overflow_q);

  prio_enc16 u_prio_enc16 (
    .in_i   (eligible),
    .code_o (enc_code),
    .any_o  (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      req_q      <= req;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_any) begin
            out_code_q  <= enc_code;
            out_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n, and SHALL have no parameters (width fixed at 16 lines).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  16  raw request lines, level, synchronous to clk.
REQ-005 mask  input  16  per-line enable; 1 = line eligible for service.
REQ-006 out_ready  input  1  consumer accepts out_code this cycle.
REQ-007 clr_ovf  input  1  synchronous clear of overflow.
REQ-008 out_code  output  4  index of the line being presented.
REQ-009 out_valid  output  1  out_code valid; handshake completes when out_valid and out_ready are both high at a rising edge.
REQ-010 pending  output  16  registered pending-request vector.
REQ-011 overflow  output  1  sticky flag: a request was lost because its line was already pending.

Function
REQ-012 The block SHALL register req into req_q every cycle; rise = req & ~req_q.
REQ-013 At each edge, pending[i] SHALL be set if rise[i]=1, cleared if line i is served this cycle, and held otherwise; set wins over a simultaneous clear.
REQ-014 The FSM SHALL have two states: IDLE and PRESENT.
REQ-015 In IDLE, if (pending & mask) != 0, the block SHALL load out_code with the highest set index of (pending & mask), set out_valid=1, and go to PRESENT; otherwise it SHALL stay in IDLE with out_valid=0.
REQ-016 Priority SHALL be highest index wins (bit 15 over bit 0), the same order as the downstream 16-to-4 encoder.
REQ-017 In PRESENT, out_code and out_valid SHALL stay stable until the handshake; a mask change SHALL NOT withdraw or change the presented code.
REQ-018 On handshake, the block SHALL clear pending[out_code] (subject to REQ-013), drive out_valid=0, and return to IDLE; a new grant needs at least one IDLE cycle, so peak throughput is one grant per 2 cycles.
REQ-019 Latency: for a req rise sampled at edge k, pending SHALL be set after edge k and out_valid SHALL be high after edge k+1 when the block is IDLE with no higher-priority line pending.
REQ-020 overflow SHALL set when rise[i]=1 and pending[i]=1 before the edge, for any i (including the line currently being served). clr_ovf SHALL clear it, and set wins over a simultaneous clear.
REQ-021 Masked lines SHALL still capture into pending and SHALL become eligible as soon as they are unmasked.
REQ-022 All outputs SHALL be driven directly from registers.

Reset
REQ-023 On rst_n=0, state SHALL be IDLE and req_q, pending, out_code, out_valid and overflow SHALL all be 0, asynchronously.
REQ-024 A req line that is high at reset release SHALL count as a rise at the first edge after release.
REQ-025 A reset during PRESENT SHALL drop the presented request without a handshake.

Structure
REQ-026 The state encoding (IDLE, PRESENT) and the width constants (N_LINES=16, CODE_W=4) SHALL live in a shared package.
REQ-027 The highest-index search SHALL be a combinational sub-module, prio_enc16 (16-bit in, 4-bit code, any flag).

Verification
REQ-028 Single line: req[5] rises, mask=FFFF, out_ready=1 -> out_valid high 2 edges later with out_code=5; pending[5]=0 after the handshake.
REQ-029 Priority: req[3] and req[12] rise together, out_ready=1 -> out_code=12 then out_code=3, with exactly one idle cycle between the grants.
REQ-030 Backpressure: out_ready=0 for 10 cycles while req[1] rises during PRESENT on 7 -> out_code holds 7; after ready, 1 is granted.
REQ-031 Overflow: req[4] pulses twice before service -> overflow=1 and one grant of 4; clr_ovf -> overflow=0.
REQ-032 Mask/race: mask[9]=0, req[9] rises -> no grant and pending[9]=1; unmask -> code 9. Re-rise of 9 on its handshake edge -> pending[9] stays 1 and overflow=1.
REQ-033 Reset mid-PRESENT: rst_n low while out_valid=1 -> all outputs 0 immediately.
